// File: rtl/rptr_empty_if.sv
// Read-side bundle of the async FIFO: pop request and synchronised write pointer in,
// read address, Gray read pointer and occupancy/status flags out.
interface rptr_empty_if #(
  parameter int ADDRSIZE = 4
);
  logic                rinc;
  logic [ADDRSIZE:0]   rq2_wptr;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr;
  logic                rempty;
  logic                raempty;
  logic [ADDRSIZE:0]   rlevel;
  logic                runderflow;

  modport master (
    output rinc, rq2_wptr,
    input  raddr, rptr, rempty, raempty, rlevel, runderflow
  );

  modport slave (
    input  rinc, rq2_wptr,
    output raddr, rptr, rempty, raempty, rlevel, runderflow
  );
endinterface

// File: rtl/rptr_empty.sv
// Read-domain pointer and empty/almost-empty/occupancy/underflow controller of the async FIFO.
// Every flag derives from the same next-pointer and synchronised write pointer, so they never disagree.
module rptr_empty #(
  parameter int ADDRSIZE      = 4,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic        rclk,
  input  logic        rrst_n,
  rptr_empty_if.slave bus
);
  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] AE_TH = PW'(AEMPTY_THRESH);

  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] rlevel_q, rlevel_d;
  logic          rempty_q, rempty_d;
  logic          raempty_q, raempty_d;
  logic          runderflow_q, runderflow_d;

  logic          pop;
  logic [PW-1:0] wbin_s;

  // Gray-to-binary as an XOR prefix running down from the MSB.
  always_comb begin
    wbin_s = '0;
    wbin_s[PW-1] = bus.rq2_wptr[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      wbin_s[i] = wbin_s[i+1] ^ bus.rq2_wptr[i];
    end
  end

  always_comb begin
    pop          = bus.rinc & ~rempty_q;
    rbin_d       = rbin_q + {{(PW-1){1'b0}}, pop};
    rptr_d       = (rbin_d >> 1) ^ rbin_d;
    rempty_d     = (rptr_d == bus.rq2_wptr);
    rlevel_d     = wbin_s - rbin_d;
    raempty_d    = (rlevel_d <= AE_TH);
    runderflow_d = runderflow_q | (bus.rinc & rempty_q);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q       <= '0;
      rptr_q       <= '0;
      rlevel_q     <= '0;
      rempty_q     <= 1'b1;
      raempty_q    <= 1'b1;
      runderflow_q <= 1'b0;
    end else begin
      rbin_q       <= rbin_d;
      rptr_q       <= rptr_d;
      rlevel_q     <= rlevel_d;
      rempty_q     <= rempty_d;
      raempty_q    <= raempty_d;
      runderflow_q <= runderflow_d;
    end
  end

  assign bus.raddr      = rbin_q[ADDRSIZE-1:0];
  assign bus.rptr       = rptr_q;
  assign bus.rempty     = rempty_q;
  assign bus.raempty    = raempty_q;
  assign bus.rlevel     = rlevel_q;
  assign bus.runderflow = runderflow_q;
endmodule

// File: tb/tb_rptr_empty.sv
// Bench for rptr_empty: directed fill/drain/wrap/underflow/reset plus random traffic, checked
// against a write-count/read-count occupancy model; three instances cover thresholds 2, 0 and 16.
module tb_rptr_empty;
  localparam int AW = 4;
  localparam int PW = AW + 1;

  logic          rclk   = 1'b0;
  logic          rrst_n = 1'b1;
  logic          rinc   = 1'b0;
  logic [PW-1:0] wptr   = '0;

  always #5 rclk = ~rclk;

  rptr_empty_if #(.ADDRSIZE(AW)) bus_a ();
  rptr_empty_if #(.ADDRSIZE(AW)) bus_z ();
  rptr_empty_if #(.ADDRSIZE(AW)) bus_f ();

  assign bus_a.rinc = rinc;  assign bus_a.rq2_wptr = wptr;
  assign bus_z.rinc = rinc;  assign bus_z.rq2_wptr = wptr;
  assign bus_f.rinc = rinc;  assign bus_f.rq2_wptr = wptr;

  rptr_empty #(.ADDRSIZE(AW), .AEMPTY_THRESH(2))  u_dut     (.rclk(rclk), .rrst_n(rrst_n), .bus(bus_a.slave));
  rptr_empty #(.ADDRSIZE(AW), .AEMPTY_THRESH(0))  u_dut_t0  (.rclk(rclk), .rrst_n(rrst_n), .bus(bus_z.slave));
  rptr_empty #(.ADDRSIZE(AW), .AEMPTY_THRESH(16)) u_dut_t16 (.rclk(rclk), .rrst_n(rrst_n), .bus(bus_f.slave));

  int total = 0;
  int bad   = 0;
  int wcnt  = 0;
  int rcnt  = 0;
  int m_level = 0;
  bit m_uf  = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] gray(input int n);
    logic [PW-1:0] b;
    b = PW'(n & 31);
    return b ^ (b >> 1);
  endfunction

  task automatic check_all();
    chk("raddr",      int'(bus_a.raddr),      rcnt % 16);
    chk("rptr",       int'(bus_a.rptr),       int'(gray(rcnt)));
    chk("rempty",     int'(bus_a.rempty),     int'(m_level == 0));
    chk("rlevel",     int'(bus_a.rlevel),     m_level);
    chk("raempty_t2", int'(bus_a.raempty),    int'(m_level <= 2));
    chk("raempty_t0", int'(bus_z.raempty),    int'(m_level == 0));
    chk("raempty_t16", int'(bus_f.raempty),   1);
    chk("rlevel_t0",  int'(bus_z.rlevel),     m_level);
    chk("runderflow", int'(bus_a.runderflow), int'(m_uf));
  endtask

  // One rclk edge: apply inputs, update the occupancy model on the edge, check just after it.
  task automatic cycle(input bit do_rd, input bit do_wr);
    rinc = do_rd;
    if (do_wr) wcnt++;
    wptr = gray(wcnt);
    @(posedge rclk);
    if (do_rd && m_level != 0) rcnt++;
    else if (do_rd) m_uf = 1'b1;
    m_level = wcnt - rcnt;
    #1;
    check_all();
  endtask

  task automatic do_reset();
    #2;
    rrst_n = 1'b0;
    #1;
    wcnt = 0; rcnt = 0; m_level = 0; m_uf = 1'b0;
    check_all();
    rinc = 1'b0;
    wptr = '0;
    @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  initial begin
    #1 rrst_n = 1'b0;
    #1 check_all();
    @(negedge rclk);
    rrst_n = 1'b1;
    cycle(0, 0);

    for (int i = 0; i < 16; i++) cycle(0, 1);
    chk("full_level", int'(bus_a.rlevel), 16);
    for (int i = 0; i < 16; i++) cycle(1, 0);
    chk("drained_empty", int'(bus_a.rempty), 1);
    cycle(1, 0);
    chk("uf_set", int'(bus_a.runderflow), 1);
    cycle(0, 0);

    cycle(0, 1);
    for (int i = 0; i < 40; i++) begin
      cycle(1, 1);
      chk("simul_level", int'(bus_a.rlevel), 1);
    end
    cycle(1, 0);

    for (int i = 0; i < 600; i++) begin
      bit rd, wr;
      rd = ($urandom_range(0, 99) < 45);
      wr = ($urandom_range(0, 99) < 50) && (wcnt - rcnt < 16);
      cycle(rd, wr);
    end

    for (int i = 0; i < 20 && m_level > 0; i++) cycle(1, 0);
    for (int i = 0; i < 20 && m_level < 5; i++) cycle(0, 1);
    chk("pre_reset_level", int'(bus_a.rlevel), 5);
    do_reset();

    for (int i = 0; i < 200; i++) begin
      bit rd, wr;
      rd = ($urandom_range(0, 99) < 50);
      wr = ($urandom_range(0, 99) < 50) && (wcnt - rcnt < 16);
      cycle(rd, wr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
